// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU execution unit: function codes
// and the branch-mask kill test used at entry and in every stage.
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SL   = 4'd1;
   localparam logic [3:0] OP_SEQ  = 4'd2;
   localparam logic [3:0] OP_SNE  = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SR   = 4'd5;
   localparam logic [3:0] OP_OR   = 4'd6;
   localparam logic [3:0] OP_AND  = 4'd7;
   localparam logic [3:0] OP_SUB  = 4'd10;
   localparam logic [3:0] OP_SRA  = 4'd11;
   localparam logic [3:0] OP_SLT  = 4'd12;
   localparam logic [3:0] OP_SGE  = 4'd13;
   localparam logic [3:0] OP_SLTU = 4'd14;
   localparam logic [3:0] OP_SGEU = 4'd15;

   localparam int MAX_BR_MASK_W = 64;

   typedef enum logic [3:0] {
      FCN_ADD  = OP_ADD,
      FCN_SL   = OP_SL,
      FCN_SEQ  = OP_SEQ,
      FCN_SNE  = OP_SNE,
      FCN_XOR  = OP_XOR,
      FCN_SR   = OP_SR,
      FCN_OR   = OP_OR,
      FCN_AND  = OP_AND,
      FCN_SUB  = OP_SUB,
      FCN_SRA  = OP_SRA,
      FCN_SLT  = OP_SLT,
      FCN_SGE  = OP_SGE,
      FCN_SLTU = OP_SLTU,
      FCN_SGEU = OP_SGEU
   } alu_fcn_e;

   // Callers zero-extend their masks to MAX_BR_MASK_W bits.
   function automatic logic is_killed(input logic [MAX_BR_MASK_W-1:0] mask,
                                      input logic [MAX_BR_MASK_W-1:0] mispred);
      return |(mask & mispred);
   endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational integer ALU: (op_fcn, fcn_dw, rs1, rs2) -> result, with the
// 32-bit W form on 64-bit datapaths.
module alu_core
   import alu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [3:0]      op_fcn,
   input  logic            fcn_dw,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic [XLEN-1:0] result
);

   logic            w_mode;
   logic [5:0]      shamt;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic [XLEN-1:0] sr_src;
   logic [XLEN-1:0] raw;

   always_comb begin
      w_mode = (XLEN == 64) && !fcn_dw;
      shamt  = (XLEN == 64 && fcn_dw) ? rs2[5:0] : {1'b0, rs2[4:0]};
      // Sign-extended W operands keep both signed and unsigned ordering intact,
      // so the compares need no separate 32-bit path.
      a      = w_mode ? XLEN'($signed(rs1[31:0])) : rs1;
      b      = w_mode ? XLEN'($signed(rs2[31:0])) : rs2;
      sr_src = w_mode ? XLEN'(rs1[31:0]) : rs1;
      raw    = '0;
      case (alu_fcn_e'(op_fcn))
         FCN_ADD:  raw = a + b;
         FCN_SUB:  raw = a - b;
         FCN_SL:   raw = a << shamt;
         FCN_SR:   raw = sr_src >> shamt;
         FCN_SRA:  raw = XLEN'($signed(a) >>> shamt);
         FCN_XOR:  raw = a ^ b;
         FCN_OR:   raw = a | b;
         FCN_AND:  raw = a & b;
         FCN_SEQ:  raw = XLEN'(a == b);
         FCN_SNE:  raw = XLEN'(a != b);
         FCN_SLT:  raw = XLEN'($signed(a) < $signed(b));
         FCN_SGE:  raw = XLEN'($signed(a) >= $signed(b));
         FCN_SLTU: raw = XLEN'(a < b);
         FCN_SGEU: raw = XLEN'(a >= b);
         default:  raw = '0;
      endcase
      result = w_mode ? XLEN'($signed(raw[31:0])) : raw;
   end

endmodule

// File: rtl/pipelined_alu_exe_unit.sv
// Integer ALU execution unit with LATENCY pipeline stages, per-stage branch-mask
// kill, and one bypass port per stage.
module pipelined_alu_exe_unit
   import alu_pkg::*;
#(
   parameter int XLEN      = 64,
   parameter int LATENCY   = 1,
   parameter int BR_MASK_W = 20,
   parameter int ROB_IDX_W = 7,
   parameter int PREG_W    = 7
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      io_req_valid,
   input  logic [3:0]                io_req_bits_op_fcn,
   input  logic                      io_req_bits_fcn_dw,
   input  logic [BR_MASK_W-1:0]      io_req_bits_br_mask,
   input  logic [ROB_IDX_W-1:0]      io_req_bits_rob_idx,
   input  logic [PREG_W-1:0]         io_req_bits_pdst,
   input  logic [XLEN-1:0]           io_req_bits_rs1_data,
   input  logic [XLEN-1:0]           io_req_bits_rs2_data,
   input  logic                      io_req_bits_kill,
   input  logic [BR_MASK_W-1:0]      io_brupdate_resolve_mask,
   input  logic [BR_MASK_W-1:0]      io_brupdate_mispred_mask,
   input  logic                      io_flush,
   output logic                      io_resp_valid,
   output logic [ROB_IDX_W-1:0]      io_resp_bits_rob_idx,
   output logic [PREG_W-1:0]         io_resp_bits_pdst,
   output logic [XLEN-1:0]           io_resp_bits_data,
   output logic [LATENCY-1:0]        io_bypass_valid,
   output logic [LATENCY*PREG_W-1:0] io_bypass_pdst,
   output logic [LATENCY*XLEN-1:0]   io_bypass_data,
   output logic                      io_busy
);

   logic [XLEN-1:0]    entry_result;
   logic               entry_valid;
   logic [LATENCY-1:0] stage_valid;

   alu_core #(.XLEN(XLEN)) u_alu_core (
      .op_fcn (io_req_bits_op_fcn),
      .fcn_dw (io_req_bits_fcn_dw),
      .rs1    (io_req_bits_rs1_data),
      .rs2    (io_req_bits_rs2_data),
      .result (entry_result)
   );

   assign entry_valid = io_req_valid && !io_req_bits_kill && !io_flush &&
                        !is_killed(MAX_BR_MASK_W'(io_req_bits_br_mask),
                                   MAX_BR_MASK_W'(io_brupdate_mispred_mask));

   for (genvar i = 0; i < LATENCY; i++) begin : g_stage
      logic                 valid;
      logic                 kill;
      logic [BR_MASK_W-1:0] mask;
      logic [ROB_IDX_W-1:0] rob_idx;
      logic [PREG_W-1:0]    pdst;
      logic [XLEN-1:0]      data;
      logic                 in_valid;
      logic [BR_MASK_W-1:0] in_mask;
      logic [ROB_IDX_W-1:0] in_rob_idx;
      logic [PREG_W-1:0]    in_pdst;
      logic [XLEN-1:0]      in_data;

      if (i == 0) begin : g_first
         assign in_valid   = entry_valid;
         assign in_mask    = io_req_bits_br_mask;
         assign in_rob_idx = io_req_bits_rob_idx;
         assign in_pdst    = io_req_bits_pdst;
         assign in_data    = entry_result;
      end else begin : g_next
         assign in_valid   = g_stage[i-1].valid && !g_stage[i-1].kill;
         assign in_mask    = g_stage[i-1].mask;
         assign in_rob_idx = g_stage[i-1].rob_idx;
         assign in_pdst    = g_stage[i-1].pdst;
         assign in_data    = g_stage[i-1].data;
      end

      assign kill = io_flush || is_killed(MAX_BR_MASK_W'(mask),
                                          MAX_BR_MASK_W'(io_brupdate_mispred_mask));

      always_ff @(posedge clock) begin
         if (!reset) valid <= 1'b0;
         else        valid <= in_valid;
      end

      // NOTE: payload registers are deliberately left out of reset; they are only
      // looked at while the stage valid is set, so resetting them buys nothing.
      always_ff @(posedge clock) begin
         mask    <= in_mask & ~io_brupdate_resolve_mask;
         rob_idx <= in_rob_idx;
         pdst    <= in_pdst;
         data    <= in_data;
      end

      assign stage_valid[i]                    = valid;
      assign io_bypass_valid[i]                = valid && !kill;
      assign io_bypass_pdst[i*PREG_W +: PREG_W] = pdst;
      assign io_bypass_data[i*XLEN +: XLEN]     = data;
   end

   assign io_resp_valid        = g_stage[LATENCY-1].valid && !g_stage[LATENCY-1].kill;
   assign io_resp_bits_rob_idx = g_stage[LATENCY-1].rob_idx;
   assign io_resp_bits_pdst    = g_stage[LATENCY-1].pdst;
   assign io_resp_bits_data    = g_stage[LATENCY-1].data;
   assign io_busy              = |stage_valid;

endmodule

// File: tb/tb_pipelined_alu_exe_unit.sv
// Scoreboard bench for pipelined_alu_exe_unit at LATENCY=3, XLEN=64: stimulus
// pushes expected responses, a negedge monitor pops and compares them.
module tb_pipelined_alu_exe_unit;
   import alu_pkg::*;

   localparam int XLEN = 64;
   localparam int LAT  = 3;
   localparam int BRW  = 20;
   localparam int ROBW = 7;
   localparam int PW   = 7;

   typedef struct {
      logic [ROBW-1:0] rob;
      logic [PW-1:0]   pdst;
      logic [XLEN-1:0] data;
   } exp_t;

   logic                 clock = 1'b0;
   logic                 reset = 1'b0;
   logic                 io_req_valid = 1'b0;
   logic [3:0]           io_req_bits_op_fcn = '0;
   logic                 io_req_bits_fcn_dw = 1'b1;
   logic [BRW-1:0]       io_req_bits_br_mask = '0;
   logic [ROBW-1:0]      io_req_bits_rob_idx = '0;
   logic [PW-1:0]        io_req_bits_pdst = '0;
   logic [XLEN-1:0]      io_req_bits_rs1_data = '0;
   logic [XLEN-1:0]      io_req_bits_rs2_data = '0;
   logic                 io_req_bits_kill = 1'b0;
   logic [BRW-1:0]       io_brupdate_resolve_mask = '0;
   logic [BRW-1:0]       io_brupdate_mispred_mask = '0;
   logic                 io_flush = 1'b0;
   logic                 io_resp_valid;
   logic [ROBW-1:0]      io_resp_bits_rob_idx;
   logic [PW-1:0]        io_resp_bits_pdst;
   logic [XLEN-1:0]      io_resp_bits_data;
   logic [LAT-1:0]       io_bypass_valid;
   logic [LAT*PW-1:0]    io_bypass_pdst;
   logic [LAT*XLEN-1:0]  io_bypass_data;
   logic                 io_busy;

   exp_t sb[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_err = 0;

   pipelined_alu_exe_unit #(
      .XLEN(XLEN), .LATENCY(LAT), .BR_MASK_W(BRW), .ROB_IDX_W(ROBW), .PREG_W(PW)
   ) dut (
      .clock                    (clock),
      .reset                    (reset),
      .io_req_valid             (io_req_valid),
      .io_req_bits_op_fcn       (io_req_bits_op_fcn),
      .io_req_bits_fcn_dw       (io_req_bits_fcn_dw),
      .io_req_bits_br_mask      (io_req_bits_br_mask),
      .io_req_bits_rob_idx      (io_req_bits_rob_idx),
      .io_req_bits_pdst         (io_req_bits_pdst),
      .io_req_bits_rs1_data     (io_req_bits_rs1_data),
      .io_req_bits_rs2_data     (io_req_bits_rs2_data),
      .io_req_bits_kill         (io_req_bits_kill),
      .io_brupdate_resolve_mask (io_brupdate_resolve_mask),
      .io_brupdate_mispred_mask (io_brupdate_mispred_mask),
      .io_flush                 (io_flush),
      .io_resp_valid            (io_resp_valid),
      .io_resp_bits_rob_idx     (io_resp_bits_rob_idx),
      .io_resp_bits_pdst        (io_resp_bits_pdst),
      .io_resp_bits_data        (io_resp_bits_data),
      .io_bypass_valid          (io_bypass_valid),
      .io_bypass_pdst           (io_bypass_pdst),
      .io_bypass_data           (io_bypass_data),
      .io_busy                  (io_busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance one clock; one-shot inputs are cleared 1 time unit after the edge.
   task automatic cycle();
      @(posedge clock);
      #1;
      io_req_valid             = 1'b0;
      io_req_bits_kill         = 1'b0;
      io_brupdate_resolve_mask = '0;
      io_brupdate_mispred_mask = '0;
      io_flush                 = 1'b0;
   endtask

   task automatic req(input logic [3:0] fcn, input logic dw, input logic [63:0] a,
                      input logic [63:0] b, input logic [BRW-1:0] mask,
                      input logic [ROBW-1:0] rob, input logic [PW-1:0] pdst,
                      input logic expect_it, input logic [63:0] exp_data);
      io_req_valid         = 1'b1;
      io_req_bits_op_fcn   = fcn;
      io_req_bits_fcn_dw   = dw;
      io_req_bits_rs1_data = a;
      io_req_bits_rs2_data = b;
      io_req_bits_br_mask  = mask;
      io_req_bits_rob_idx  = rob;
      io_req_bits_pdst     = pdst;
      if (expect_it) sb.push_back('{rob, pdst, exp_data});
   endtask

   initial begin : monitor
      forever begin
         @(negedge clock);
         if (io_resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_resp: got rob 0x%0h pdst 0x%0h data 0x%0h, expected no response",
                        io_resp_bits_rob_idx, io_resp_bits_pdst, io_resp_bits_data);
            end else begin
               mon_e = sb.pop_front();
               check("resp_rob",  64'(io_resp_bits_rob_idx), 64'(mon_e.rob));
               check("resp_pdst", 64'(io_resp_bits_pdst),    64'(mon_e.pdst));
               check("resp_data", io_resp_bits_data,         mon_e.data);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      reset = 1'b0;
      cycle();
      cycle();
      reset = 1'b1;
      check("rst_resp_valid", 64'(io_resp_valid), 64'd0);
      check("rst_busy",       64'(io_busy),       64'd0);
      check("rst_bypass",     64'(io_bypass_valid), 64'd0);

      // 1: latency and bypass walk
      req(OP_ADD, 1'b1, 64'd5, 64'd7, '0, 7'd1, 7'd9, 1'b1, 64'd12);
      cycle();
      check("bypass_v_s1",    64'(io_bypass_valid), 64'b001);
      check("bypass_pdst_s1", 64'(io_bypass_pdst[PW-1:0]), 64'd9);
      check("bypass_data_s1", io_bypass_data[XLEN-1:0], 64'd12);
      cycle();
      check("bypass_v_s2",    64'(io_bypass_valid), 64'b010);
      cycle();
      check("bypass_v_s3",    64'(io_bypass_valid), 64'b100);
      check("resp_valid_lat", 64'(io_resp_valid), 64'd1);
      cycle();
      check("busy_drained_1", 64'(io_busy), 64'd0);

      // 2: function coverage, back to back
      req(OP_ADD,  1'b0, 64'h7FFF_FFFF, 64'd1, '0, 7'd2, 7'd10, 1'b1, 64'hFFFF_FFFF_8000_0000); cycle();
      req(OP_SRA,  1'b0, 64'h8000_0000, 64'd4, '0, 7'd3, 7'd11, 1'b1, 64'hFFFF_FFFF_F800_0000); cycle();
      req(OP_SUB,  1'b1, 64'd0, 64'd1, '0, 7'd4, 7'd12, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF); cycle();
      req(OP_SL,   1'b1, 64'd1, 64'd63, '0, 7'd5, 7'd13, 1'b1, 64'h8000_0000_0000_0000); cycle();
      req(OP_SL,   1'b1, 64'd1, 64'd65, '0, 7'd6, 7'd14, 1'b1, 64'd2); cycle();
      req(OP_SL,   1'b0, 64'd1, 64'd31, '0, 7'd7, 7'd15, 1'b1, 64'hFFFF_FFFF_8000_0000); cycle();
      req(OP_SR,   1'b1, 64'h8000_0000_0000_0000, 64'd63, '0, 7'd8, 7'd16, 1'b1, 64'd1); cycle();
      req(OP_SR,   1'b0, 64'hFFFF_FFFF_8000_0000, 64'd36, '0, 7'd9, 7'd17, 1'b1, 64'h0800_0000); cycle();
      req(OP_SRA,  1'b1, 64'h8000_0000_0000_0000, 64'd4, '0, 7'd10, 7'd18, 1'b1, 64'hF800_0000_0000_0000); cycle();
      req(OP_SLT,  1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, '0, 7'd11, 7'd19, 1'b1, 64'd1); cycle();
      req(OP_SLTU, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, '0, 7'd12, 7'd20, 1'b1, 64'd0); cycle();
      req(OP_SGE,  1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, '0, 7'd13, 7'd21, 1'b1, 64'd0); cycle();
      req(OP_SGEU, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, '0, 7'd14, 7'd22, 1'b1, 64'd1); cycle();
      req(OP_SEQ,  1'b1, 64'd5, 64'd5, '0, 7'd15, 7'd23, 1'b1, 64'd1); cycle();
      req(OP_SNE,  1'b1, 64'd5, 64'd5, '0, 7'd16, 7'd24, 1'b1, 64'd0); cycle();
      req(OP_XOR,  1'b1, 64'hF0F0, 64'h0FF0, '0, 7'd17, 7'd25, 1'b1, 64'hFF00); cycle();
      req(OP_OR,   1'b1, 64'hF0F0, 64'h0FF0, '0, 7'd18, 7'd26, 1'b1, 64'hFFF0); cycle();
      req(OP_AND,  1'b1, 64'hF0F0, 64'h0FF0, '0, 7'd19, 7'd27, 1'b1, 64'h00F0); cycle();
      req(4'd8,    1'b1, 64'd3, 64'd4, '0, 7'd20, 7'd28, 1'b1, 64'd0); cycle();
      repeat (LAT) cycle();

      // 3: mispredict kills the younger uop in stage 2, older one survives
      req(OP_ADD, 1'b1, 64'd100, 64'd1, 20'h1, 7'd30, 7'd40, 1'b1, 64'd101); cycle();
      req(OP_ADD, 1'b1, 64'd200, 64'd1, 20'h4, 7'd31, 7'd41, 1'b0, 64'd0);   cycle();
      cycle();
      io_brupdate_mispred_mask = 20'h4;
      cycle();
      repeat (LAT) cycle();
      check("busy_after_mispred", 64'(io_busy), 64'd0);

      // 4: resolve and mispredict on the same bit, then resolve alone
      req(OP_ADD, 1'b1, 64'd1, 64'd1, 20'h4, 7'd32, 7'd42, 1'b0, 64'd0); cycle();
      io_brupdate_resolve_mask = 20'h4;
      io_brupdate_mispred_mask = 20'h4;
      cycle();
      repeat (LAT) cycle();
      req(OP_ADD, 1'b1, 64'd2, 64'd2, 20'h4, 7'd33, 7'd43, 1'b1, 64'd4); cycle();
      io_brupdate_resolve_mask = 20'h4;
      cycle();
      io_brupdate_mispred_mask = 20'h4;
      cycle();
      repeat (LAT) cycle();
      // entry kills: explicit kill, and mispredict on the request's own mask
      req(OP_ADD, 1'b1, 64'd3, 64'd3, '0, 7'd34, 7'd44, 1'b0, 64'd0);
      io_req_bits_kill = 1'b1;
      cycle();
      check("busy_entry_kill", 64'(io_busy), 64'd0);
      req(OP_ADD, 1'b1, 64'd3, 64'd3, 20'h8, 7'd35, 7'd45, 1'b0, 64'd0);
      io_brupdate_mispred_mask = 20'h8;
      cycle();
      check("busy_entry_mispred", 64'(io_busy), 64'd0);

      // 5: six back-to-back requests, flush with the fourth one
      for (int i = 0; i < 6; i++) begin
         req(OP_ADD, 1'b1, 64'(i), 64'd1000, '0, 7'(50 + i), 7'(60 + i), i >= 4, 64'(1000 + i));
         if (i == 3) io_flush = 1'b1;
         cycle();
      end
      repeat (LAT) cycle();
      check("busy_after_flush", 64'(io_busy), 64'd0);

      // 6: reset mid-flight drops both uops; next request is normal
      req(OP_ADD, 1'b1, 64'd9, 64'd9, '0, 7'd70, 7'd80, 1'b0, 64'd0); cycle();
      req(OP_ADD, 1'b1, 64'd8, 64'd8, '0, 7'd71, 7'd81, 1'b0, 64'd0); cycle();
      reset = 1'b0;
      cycle();
      reset = 1'b1;
      check("busy_after_reset",   64'(io_busy), 64'd0);
      check("resp_after_reset",   64'(io_resp_valid), 64'd0);
      check("bypass_after_reset", 64'(io_bypass_valid), 64'd0);
      req(OP_SUB, 1'b1, 64'd50, 64'd8, '0, 7'd72, 7'd82, 1'b1, 64'd42); cycle();
      repeat (LAT + 2) cycle();

      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
